// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises instruction and data requests onto one RAM port.
// Data wins over instruction, RAM errors are retried, and memerr latches if retries run out.
module mem_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        DRESP,
        IACC,
        IRESP,
        RETRY
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] lat_addr;
    logic [31:0] lat_store;
    logic        lat_write;
    logic        lat_data;
    logic [1:0]  retry_cnt;
    logic        saturated;

    assign saturated = (retry_cnt == 2'd3);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // RAM command and hit pulses decode from the state alone, so reset clears them at once.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        dhit       = 1'b0;
        ihit       = 1'b0;
        unique case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end
            end
            DACC: begin
                ramREN   = ~lat_write;
                ramWEN   = lat_write;
                ramaddr  = lat_addr;
                ramstore = lat_store;
                if (ramstate == RAM_ACCESS) begin
                    next_state = DRESP;
                end else if (ramstate == RAM_ERROR) begin
                    next_state = saturated ? DRESP : RETRY;
                end
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = lat_addr;
                if (ramstate == RAM_ACCESS) begin
                    next_state = IRESP;
                end else if (ramstate == RAM_ERROR) begin
                    next_state = saturated ? IRESP : RETRY;
                end
            end
            DRESP: begin
                dhit       = 1'b1;
                next_state = IDLE;
            end
            IRESP: begin
                ihit       = 1'b1;
                next_state = IDLE;
            end
            RETRY: begin
                next_state = lat_data ? DACC : IACC;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latching, retry counting and load-register capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_addr  <= '0;
            lat_store <= '0;
            lat_write <= 1'b0;
            lat_data  <= 1'b0;
            retry_cnt <= '0;
            memerr    <= 1'b0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    retry_cnt <= '0;
                    if (dREN || dWEN) begin
                        lat_addr  <= daddr;
                        lat_store <= dstore;
                        lat_write <= dWEN;
                        lat_data  <= 1'b1;
                    end else if (iREN) begin
                        lat_addr  <= iaddr;
                        lat_store <= '0;
                        lat_write <= 1'b0;
                        lat_data  <= 1'b0;
                    end
                end
                DACC: begin
                    if (ramstate == RAM_ACCESS) begin
                        if (!lat_write) begin
                            dload <= ramload;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        if (saturated) begin
                            memerr <= 1'b1;
                            if (!lat_write) begin
                                dload <= ERR_WORD;
                            end
                        end else begin
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end
                end
                IACC: begin
                    if (ramstate == RAM_ACCESS) begin
                        iload <= ramload;
                    end else if (ramstate == RAM_ERROR) begin
                        if (saturated) begin
                            memerr <= 1'b1;
                            iload  <= ERR_WORD;
                        end else begin
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant priority, wait states,
// retry/error handling and asynchronous reset in flight.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #2;
        n_compared++;
        if ({ihit, dhit, ramREN, ramWEN, memerr, ramaddr, ramstore, iload, dload} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b %h %h %h %h expected all zero",
                     ihit, dhit, ramREN, ramWEN, memerr, ramaddr, ramstore, iload, dload);
        end
        step();
        nRST = 1'b1;
        step();
        n_compared++;
        if (ramREN !== 1'b0 || ihit !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_idle: got ramREN=%b ihit=%b expected 0/0", ramREN, ihit);
        end
    endtask

    task automatic test_inst_read();
        iREN = 1; iaddr = 32'h100; ramstate = ACCESS; ramload = 32'h2402000A;
        step();
        iREN = 0;
        n_compared++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin
            n_mismatched++;
            $display("FAIL inst_cmd: got REN=%b WEN=%b addr=%h expected 1/0/00000100", ramREN, ramWEN, ramaddr);
        end
        step();
        n_compared++;
        if (ihit !== 1'b1 || iload !== 32'h2402000A || ramREN !== 1'b0) begin
            n_mismatched++;
            $display("FAIL inst_hit: got ihit=%b iload=%h REN=%b expected 1/2402000a/0", ihit, iload, ramREN);
        end
        step();
        n_compared++;
        if (ihit !== 1'b0) begin
            n_mismatched++;
            $display("FAIL inst_hit_pulse: got ihit=%b expected 0", ihit);
        end
        ramstate = FREE;
    endtask

    task automatic test_priority();
        iREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hCAFEF00D; iaddr = 32'h400;
        ramstate = FREE;
        step();
        dWEN = 0;
        n_compared++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hCAFEF00D) begin
            n_mismatched++;
            $display("FAIL prio_write_cmd: got WEN=%b REN=%b addr=%h store=%h expected 1/0/00000200/cafef00d",
                     ramWEN, ramREN, ramaddr, ramstore);
        end
        ramstate = ACCESS; ramload = 32'h11112222;
        step();
        n_compared++;
        if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h0) begin
            n_mismatched++;
            $display("FAIL prio_dhit: got dhit=%b ihit=%b dload=%h expected 1/0/00000000", dhit, ihit, dload);
        end
        step();
        n_compared++;
        if (ramREN !== 1'b0 || dhit !== 1'b0) begin
            n_mismatched++;
            $display("FAIL prio_resp_to_idle: got REN=%b dhit=%b expected 0/0", ramREN, dhit);
        end
        step();
        iREN = 0;
        n_compared++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin
            n_mismatched++;
            $display("FAIL prio_inst_cmd: got REN=%b addr=%h expected 1/00000400", ramREN, ramaddr);
        end
        step();
        n_compared++;
        if (ihit !== 1'b1 || iload !== 32'h11112222) begin
            n_mismatched++;
            $display("FAIL prio_ihit: got ihit=%b iload=%h expected 1/11112222", ihit, iload);
        end
        step();
        ramstate = FREE;
    endtask

    task automatic test_busy_wait();
        dREN = 1; daddr = 32'h300; ramstate = BUSY; ramload = 32'h12345678;
        step();
        dREN = 0; daddr = 32'hFFF;
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dhit !== 1'b0) begin
                n_mismatched++;
                $display("FAIL busy_hold[%0d]: got REN=%b addr=%h dhit=%b expected 1/00000300/0", i, ramREN, ramaddr, dhit);
            end
            step();
        end
        ramstate = ACCESS;
        n_compared++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
            n_mismatched++;
            $display("FAIL busy_access_cycle: got REN=%b addr=%h expected 1/00000300", ramREN, ramaddr);
        end
        step();
        n_compared++;
        if (dhit !== 1'b1 || dload !== 32'h12345678 || ramREN !== 1'b0) begin
            n_mismatched++;
            $display("FAIL busy_dhit: got dhit=%b dload=%h REN=%b expected 1/12345678/0", dhit, dload, ramREN);
        end
        step();
        ramstate = FREE;
    endtask

    task automatic test_retry();
        dREN = 1; daddr = 32'h500; ramstate = ERROR; ramload = 32'hA5A5A5A5;
        step();
        dREN = 0;
        for (int i = 0; i < 2; i++) begin
            n_compared++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
                n_mismatched++;
                $display("FAIL retry_acc[%0d]: got REN=%b addr=%h expected 1/00000500", i, ramREN, ramaddr);
            end
            step();
            n_compared++;
            if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin
                n_mismatched++;
                $display("FAIL retry_cycle[%0d]: got REN=%b WEN=%b addr=%h dhit=%b expected 0/0/0/0",
                         i, ramREN, ramWEN, ramaddr, dhit);
            end
            if (i == 1) ramstate = ACCESS;
            step();
        end
        step();
        n_compared++;
        if (dhit !== 1'b1 || dload !== 32'hA5A5A5A5 || memerr !== 1'b0) begin
            n_mismatched++;
            $display("FAIL retry_dhit: got dhit=%b dload=%h memerr=%b expected 1/a5a5a5a5/0", dhit, dload, memerr);
        end
        step();
        ramstate = FREE;
    endtask

    task automatic test_error_exhaust();
        dREN = 1; daddr = 32'h600; ramstate = ERROR; ramload = 32'h77777777;
        step();
        dREN = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_compared++;
            if (ramREN !== 1'b0 || memerr !== 1'b0 || dhit !== 1'b0) begin
                n_mismatched++;
                $display("FAIL exhaust_retry[%0d]: got REN=%b memerr=%b dhit=%b expected 0/0/0", i, ramREN, memerr, dhit);
            end
            step();
        end
        step();
        n_compared++;
        if (dhit !== 1'b1 || dload !== 32'hBAD1BAD1 || memerr !== 1'b1) begin
            n_mismatched++;
            $display("FAIL exhaust_dhit: got dhit=%b dload=%h memerr=%b expected 1/bad1bad1/1", dhit, dload, memerr);
        end
        iREN = 1; iaddr = 32'h640;
        step();
        step();
        iREN = 0;
        n_compared++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h640) begin
            n_mismatched++;
            $display("FAIL exhaust_inst_cmd: got REN=%b addr=%h expected 1/00000640", ramREN, ramaddr);
        end
        step();
        n_compared++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            n_mismatched++;
            $display("FAIL retry_cnt_cleared: got ihit=%b REN=%b expected 0/0", ihit, ramREN);
        end
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        step();
        step();
        n_compared++;
        if (ihit !== 1'b1 || iload !== 32'h0BADF00D || memerr !== 1'b1) begin
            n_mismatched++;
            $display("FAIL exhaust_sticky: got ihit=%b iload=%h memerr=%b expected 1/0badf00d/1", ihit, iload, memerr);
        end
        step();
        ramstate = FREE;
    endtask

    task automatic test_reset_midflight();
        dREN = 1; daddr = 32'h700; ramstate = BUSY;
        step();
        dREN = 0;
        n_compared++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h700) begin
            n_mismatched++;
            $display("FAIL midreset_cmd: got REN=%b addr=%h expected 1/00000700", ramREN, ramaddr);
        end
        #2 nRST = 1'b0;
        #1;
        n_compared++;
        if ({ihit, dhit, ramREN, ramWEN, memerr, ramaddr, ramstore, iload, dload} !== '0) begin
            n_mismatched++;
            $display("FAIL midreset_outputs: got %b/%b/%b/%b/%b %h %h %h %h expected all zero",
                     ihit, dhit, ramREN, ramWEN, memerr, ramaddr, ramstore, iload, dload);
        end
        step();
        nRST = 1'b1; ramstate = ACCESS;
        for (int i = 0; i < 2; i++) begin
            step();
            n_compared++;
            if (dhit !== 1'b0 || ramREN !== 1'b0) begin
                n_mismatched++;
                $display("FAIL midreset_no_hit[%0d]: got dhit=%b REN=%b expected 0/0", i, dhit, ramREN);
            end
        end
        dREN = 1; daddr = 32'h800; ramload = 32'h55AA55AA;
        step();
        dREN = 0;
        n_compared++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin
            n_mismatched++;
            $display("FAIL midreset_regrant: got REN=%b addr=%h expected 1/00000800", ramREN, ramaddr);
        end
        step();
        n_compared++;
        if (dhit !== 1'b1 || dload !== 32'h55AA55AA) begin
            n_mismatched++;
            $display("FAIL midreset_dhit: got dhit=%b dload=%h expected 1/55aa55aa", dhit, dload);
        end
        step();
    endtask

    task automatic test_back_to_back();
        dREN = 1; dWEN = 1; daddr = 32'h900; dstore = 32'h00000001;
        ramstate = ACCESS; ramload = 32'hDEADDEAD;
        step();
        n_compared++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1) begin
            n_mismatched++;
            $display("FAIL b2b_both_is_write: got WEN=%b REN=%b store=%h expected 1/0/00000001", ramWEN, ramREN, ramstore);
        end
        step();
        n_compared++;
        if (dhit !== 1'b1 || dload !== 32'h55AA55AA) begin
            n_mismatched++;
            $display("FAIL b2b_write_keeps_dload: got dhit=%b dload=%h expected 1/55aa55aa", dhit, dload);
        end
        step();
        n_compared++;
        if (ramWEN !== 1'b0 || dhit !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_idle_gap: got WEN=%b dhit=%b expected 0/0", ramWEN, dhit);
        end
        step();
        dREN = 0; dWEN = 0;
        n_compared++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h900) begin
            n_mismatched++;
            $display("FAIL b2b_regrant: got WEN=%b addr=%h expected 1/00000900", ramWEN, ramaddr);
        end
        step();
        n_compared++;
        if (dhit !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_second_dhit: got dhit=%b expected 1", dhit);
        end
        step();
        ramstate = FREE;
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_priority();
        test_busy_wait();
        test_retry();
        test_error_exhaust();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
